lane_scheduler: RTL and testbench

- Shares one 8-bit symbol lane between two packet requesters; the lane feeds the receive-side demux.
- Frames each granted packet as STP, payload bytes, END, and arbitrates round-robin at packet boundaries.
- Inserts a periodic skip ordered set (COM followed by SKP_LEN x SKP) between packets, never mid-packet.
- Drives IDL with out_valid low when there is nothing to send.

---
 rtl/lane_pkg.sv | 22 ++
 rtl/lane_rr_arb.sv | 26 ++
 rtl/lane_scheduler.sv | 166 ++++++++++++++++
 tb/tb_lane_scheduler.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lane_pkg.sv
// Symbol codes and FSM state encoding shared by the lane scheduler and the receive-side demux.
package lane_pkg;

    typedef enum logic [7:0] {
        COM = 8'hbc,
        SKP = 8'h1c,
        STP = 8'hfb,
        SDP = 8'h5c,
        END = 8'hfd,
        IDL = 8'h7c
    } lane_sym_code_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_STP,
        S_DATA,
        S_END,
        S_SKP_COM,
        S_SKP_SYM
    } lane_state_t;

endpackage

// File: rtl/lane_rr_arb.sv
// Two-way round-robin arbiter; o_last holds the most recent winner and only moves on i_update.
// The requester opposite o_last wins when asking, so grants alternate under steady contention.
module lane_rr_arb (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_req,
    input  logic       i_update,
    output logic       o_last
);

    logic r_last;
    logic w_win;

    // With no request at all the winner is irrelevant; the caller only updates on a request.
    assign w_win  = i_req[~r_last] ? ~r_last : r_last;
    assign o_last = r_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last <= 1'b1;
        end else if (i_update) begin
            r_last <= w_win;
        end
    end

endmodule

// File: rtl/lane_scheduler.sv
// Frames two requesters' packets onto one symbol lane (STP, payload, END) with periodic skip sets between packets.
// Symbols leave one cycle after the state that produces them; in_ready depends on state and grant only.
module lane_scheduler
    import lane_pkg::*;
#(
    parameter int SKP_INTERVAL = 64,
    parameter int SKP_LEN      = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] in_valid,
    input  logic [7:0] in_data0,
    input  logic [7:0] in_data1,
    input  logic [1:0] in_last,
    output logic [1:0] in_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_is_k,
    output logic       grant_id,
    output logic       busy
);

    localparam int               CNT_W    = $clog2(SKP_INTERVAL);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SKP_INTERVAL - 1);
    localparam logic [2:0]       IDX_LAST = 3'(SKP_LEN - 1);

    lane_state_t      r_state;
    lane_state_t      w_state_nxt;
    logic [CNT_W-1:0] r_skp_cnt;
    logic             r_skp_pending;
    logic [2:0]       r_skp_idx;
    logic [2:0]       w_skp_idx_nxt;
    logic             r_out_vld;
    logic [7:0]       r_out_dat;
    logic             r_out_k;
    logic             w_out_vld;
    logic [7:0]       w_out_dat;
    logic             w_out_k;
    logic             w_grant;
    logic             w_arb_upd;
    logic             w_decide;
    logic             w_skp_clr;
    logic             w_skp_wrap;
    logic             w_vld_g;
    logic             w_last_g;
    logic [7:0]       w_dat_g;

    lane_rr_arb u_arb (
        .clk      (clk),
        .reset    (reset),
        .i_req    (in_valid),
        .i_update (w_arb_upd),
        .o_last   (w_grant)
    );

    assign w_vld_g    = in_valid[w_grant];
    assign w_last_g   = in_last[w_grant];
    assign w_dat_g    = w_grant ? in_data1 : in_data0;
    assign w_skp_wrap = (r_skp_cnt == CNT_LAST);

    assign in_ready  = (r_state == S_DATA) ? {w_grant, ~w_grant} : 2'b00;
    assign grant_id  = w_grant;
    assign busy      = (r_state != S_IDLE);
    assign out_valid = r_out_vld;
    assign out_data  = r_out_dat;
    assign out_is_k  = r_out_k;

    always_comb begin
        w_state_nxt   = r_state;
        w_skp_idx_nxt = r_skp_idx;
        w_out_vld     = 1'b0;
        w_out_dat     = IDL;
        w_out_k       = 1'b0;
        w_skp_clr     = 1'b0;
        w_decide      = 1'b0;
        w_arb_upd     = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_decide = 1'b1;
            end
            S_STP: begin
                w_out_vld   = 1'b1;
                w_out_dat   = STP;
                w_out_k     = 1'b1;
                w_state_nxt = S_DATA;
            end
            S_DATA: begin
                // Payload may carry control code values; out_is_k stays low to mark them as data.
                if (w_vld_g) begin
                    w_out_vld = 1'b1;
                    w_out_dat = w_dat_g;
                    if (w_last_g) begin
                        w_state_nxt = S_END;
                    end
                end
            end
            S_END: begin
                w_out_vld = 1'b1;
                w_out_dat = END;
                w_out_k   = 1'b1;
                w_decide  = 1'b1;
            end
            S_SKP_COM: begin
                w_out_vld     = 1'b1;
                w_out_dat     = COM;
                w_out_k       = 1'b1;
                w_skp_clr     = 1'b1;
                w_skp_idx_nxt = 3'd0;
                w_state_nxt   = S_SKP_SYM;
            end
            S_SKP_SYM: begin
                w_out_vld = 1'b1;
                w_out_dat = SKP;
                w_out_k   = 1'b1;
                if (r_skp_idx == IDX_LAST) begin
                    w_skp_idx_nxt = 3'd0;
                    w_decide      = 1'b1;
                end else begin
                    w_skp_idx_nxt = r_skp_idx + 3'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Packet boundary: a pending skip outranks any waiting packet.
        if (w_decide) begin
            if (r_skp_pending) begin
                w_state_nxt = S_SKP_COM;
            end else if (|in_valid) begin
                w_state_nxt = S_STP;
                w_arb_upd   = 1'b1;
            end else begin
                w_state_nxt = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_skp_cnt     <= '0;
            r_skp_pending <= 1'b0;
            r_skp_idx     <= 3'd0;
            r_out_vld     <= 1'b0;
            r_out_dat     <= IDL;
            r_out_k       <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_skp_idx <= w_skp_idx_nxt;
            r_out_vld <= w_out_vld;
            r_out_dat <= w_out_dat;
            r_out_k   <= w_out_k;
            r_skp_cnt <= w_skp_wrap ? '0 : r_skp_cnt + 1'b1;
            // A wrap landing on the COM cycle keeps the flag, so that interval's skip is not lost.
            if (w_skp_wrap) begin
                r_skp_pending <= 1'b1;
            end else if (w_skp_clr) begin
                r_skp_pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lane_scheduler.sv
// Directed and randomized checks of lane_scheduler against a packet-level scoreboard and lane protocol rules.
module tb_lane_scheduler;
    import lane_pkg::*;

    localparam int SKP_INTERVAL = 16;
    localparam int SKP_LEN      = 3;
    localparam int LOGN         = 1024;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] in_valid = 2'b00;
    logic [7:0] in_data0 = 8'h00;
    logic [7:0] in_data1 = 8'h00;
    logic [1:0] in_last = 2'b00;
    logic [1:0] in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_is_k;
    logic       grant_id;
    logic       busy;

    lane_scheduler #(.SKP_INTERVAL(SKP_INTERVAL), .SKP_LEN(SKP_LEN)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data0(in_data0), .in_data1(in_data1),
        .in_last(in_last), .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_is_k(out_is_k), .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Requester-side byte queues {last, data}; dq feeds the pins, eq is what the lane must deliver.
    logic [8:0] dq0[$], dq1[$], eq0[$], eq1[$];
    logic [1:0] stall = 2'b00;
    logic [1:0] fire = 2'b00;
    int         cyc = 0;

    logic       lv[LOGN];
    logic       lk[LOGN];
    logic [7:0] ld[LOGN];
    logic       lg[LOGN];
    logic [1:0] lr[LOGN];

    logic in_pkt = 1'b0;
    logic cur = 1'b0;
    logic exp_end = 1'b0;
    int   skp_left = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push_byte(input int r, input logic [7:0] b, input logic last);
        if (r == 0) begin
            dq0.push_back({last, b});
            eq0.push_back({last, b});
        end else begin
            dq1.push_back({last, b});
            eq1.push_back({last, b});
        end
    endtask

    task automatic parse();
        logic [8:0] e;
        if (!out_valid) begin
            chk("idle_data", out_data, IDL);
            chk("idle_k", out_is_k, 1'b0);
        end else if (out_is_k) begin
            if (out_data != SKP) chk("skp_run_complete", skp_left, 0);
            case (out_data)
                STP: begin
                    chk("stp_outside_pkt", in_pkt, 1'b0);
                    in_pkt = 1'b1;
                    cur = grant_id;
                    exp_end = 1'b0;
                end
                END: begin
                    chk("end_inside_pkt", in_pkt, 1'b1);
                    chk("end_after_last", exp_end, 1'b1);
                    in_pkt = 1'b0;
                end
                COM: begin
                    chk("com_outside_pkt", in_pkt, 1'b0);
                    skp_left = SKP_LEN;
                end
                SKP: begin
                    chk("skp_after_com", (skp_left > 0), 1'b1);
                    skp_left--;
                end
                default: chk("k_code", out_data, STP);
            endcase
        end else begin
            chk("skp_run_complete", skp_left, 0);
            chk("payload_inside_pkt", in_pkt, 1'b1);
            chk("payload_before_last", exp_end, 1'b0);
            if (cur == 1'b0) begin
                chk("exp_q0_nonempty", (eq0.size() != 0), 1'b1);
                e = (eq0.size() != 0) ? eq0.pop_front() : 9'h000;
            end else begin
                chk("exp_q1_nonempty", (eq1.size() != 0), 1'b1);
                e = (eq1.size() != 0) ? eq1.pop_front() : 9'h000;
            end
            chk("payload_byte", out_data, e[7:0]);
            if (e[8]) exp_end = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (fire[0]) void'(dq0.pop_front());
        if (fire[1]) void'(dq1.pop_front());
        if (dq0.size() != 0 && !stall[0]) begin
            in_valid[0] = 1'b1; in_data0 = dq0[0][7:0]; in_last[0] = dq0[0][8];
        end else begin
            in_valid[0] = 1'b0; in_data0 = 8'h00; in_last[0] = 1'b0;
        end
        if (dq1.size() != 0 && !stall[1]) begin
            in_valid[1] = 1'b1; in_data1 = dq1[0][7:0]; in_last[1] = dq1[0][8];
        end else begin
            in_valid[1] = 1'b0; in_data1 = 8'h00; in_last[1] = 1'b0;
        end
        @(negedge clk);
        fire = in_valid & in_ready;
        if (cyc < LOGN) begin
            lv[cyc] = out_valid; lk[cyc] = out_is_k; ld[cyc] = out_data;
            lg[cyc] = grant_id;  lr[cyc] = in_ready;
        end
        parse();
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        in_valid = 2'b00; in_last = 2'b00; in_data0 = 8'h00; in_data1 = 8'h00;
        dq0.delete(); dq1.delete(); eq0.delete(); eq1.delete();
        stall = 2'b00; fire = 2'b00; cyc = 0;
        in_pkt = 1'b0; exp_end = 1'b0; skp_left = 0;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, IDL);
        chk("rst_out_is_k", out_is_k, 1'b0);
        chk("rst_in_ready", in_ready, 2'b00);
        chk("rst_grant_id", grant_id, 1'b1);
        chk("rst_busy", busy, 1'b0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic chk_sym(input string tag, input int i, input logic k, input logic [7:0] d);
        chk({tag, "_valid"}, lv[i], 1'b1);
        chk({tag, "_k"}, lk[i], k);
        chk({tag, "_data"}, ld[i], d);
    endtask

    initial begin
        int rdy0;
        int rdy1;
        int nvld;
        logic drained;

        // Single 2-byte packet from requester 0.
        do_reset();
        push_byte(0, 8'h11, 1'b0);
        push_byte(0, 8'h22, 1'b1);
        repeat (10) tick();
        chk("single_pre_idle", lv[1], 1'b0);
        chk_sym("single_stp", 2, 1'b1, STP);
        chk_sym("single_d0", 3, 1'b0, 8'h11);
        chk_sym("single_d1", 4, 1'b0, 8'h22);
        chk_sym("single_end", 5, 1'b1, END);
        chk("single_post_idle", lv[6], 1'b0);
        rdy0 = 0; rdy1 = 0;
        for (int i = 0; i < 10; i++) begin
            rdy0 += int'(lr[i][0]);
            rdy1 += int'(lr[i][1]);
        end
        chk("single_rdy0_cycles", rdy0, 2);
        chk("single_rdy1_cycles", rdy1, 0);

        // Contention: both requesters hold 1-byte packets.
        do_reset();
        push_byte(0, 8'hA0, 1'b1);
        push_byte(1, 8'hB0, 1'b1);
        repeat (10) tick();
        chk_sym("cont_stp0", 2, 1'b1, STP);
        chk_sym("cont_a0", 3, 1'b0, 8'hA0);
        chk_sym("cont_end0", 4, 1'b1, END);
        chk_sym("cont_stp1", 5, 1'b1, STP);
        chk_sym("cont_b0", 6, 1'b0, 8'hB0);
        chk_sym("cont_end1", 7, 1'b1, END);
        chk("cont_grant_first", lg[2], 1'b0);
        chk("cont_grant_second", lg[5], 1'b1);

        // Stall: requester 0 withholds valid for two cycles after the first byte.
        do_reset();
        push_byte(0, 8'h01, 1'b0);
        push_byte(0, 8'h02, 1'b0);
        push_byte(0, 8'h03, 1'b1);
        repeat (3) tick();
        stall[0] = 1'b1;
        repeat (2) tick();
        stall[0] = 1'b0;
        repeat (6) tick();
        chk_sym("stall_d0", 3, 1'b0, 8'h01);
        chk("stall_gap0_valid", lv[4], 1'b0);
        chk("stall_gap0_data", ld[4], IDL);
        chk("stall_gap1_valid", lv[5], 1'b0);
        chk("stall_gap1_data", ld[5], IDL);
        chk_sym("stall_d1", 6, 1'b0, 8'h02);
        chk_sym("stall_d2", 7, 1'b0, 8'h03);
        chk_sym("stall_end", 8, 1'b1, END);

        // Payload byte equal to the END code travels as data.
        do_reset();
        push_byte(0, 8'hfd, 1'b0);
        push_byte(0, 8'h33, 1'b1);
        repeat (8) tick();
        chk_sym("ctlval_stp", 2, 1'b1, STP);
        chk_sym("ctlval_fd", 3, 1'b0, 8'hfd);
        chk_sym("ctlval_d1", 4, 1'b0, 8'h33);
        chk_sym("ctlval_end", 5, 1'b1, END);

        // Idle lane: skip set every SKP_INTERVAL cycles.
        do_reset();
        repeat (56) tick();
        for (int p = 0; p < 3; p++) begin
            chk_sym("idle_com", 17 + 16 * p, 1'b1, COM);
            for (int s = 1; s <= SKP_LEN; s++) chk_sym("idle_skp", 17 + 16 * p + s, 1'b1, SKP);
        end
        nvld = 0;
        for (int i = 0; i < 56; i++) nvld += int'(lv[i]);
        chk("idle_valid_count", nvld, 3 * (SKP_LEN + 1));

        // 20-byte packet straddling the timer wrap: skip deferred until after END.
        do_reset();
        for (int i = 0; i < 20; i++) push_byte(0, 8'(8'h40 + i), (i == 19));
        repeat (40) tick();
        chk_sym("long_first", 3, 1'b0, 8'h40);
        chk_sym("long_last", 22, 1'b0, 8'h53);
        chk_sym("long_end", 23, 1'b1, END);
        chk_sym("long_com", 24, 1'b1, COM);
        for (int s = 1; s <= SKP_LEN; s++) chk_sym("long_skp", 24 + s, 1'b1, SKP);
        chk_sym("long_next_com", 33, 1'b1, COM);

        // Asynchronous reset in the middle of DATA.
        do_reset();
        for (int i = 0; i < 6; i++) push_byte(0, 8'(8'h60 + i), (i == 5));
        repeat (5) tick();
        chk("arst_pre_ready", in_ready, 2'b01);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_out_data", out_data, IDL);
        chk("arst_in_ready", in_ready, 2'b00);
        chk("arst_busy", busy, 1'b0);
        do_reset();
        push_byte(0, 8'hC0, 1'b1);
        push_byte(1, 8'hD0, 1'b1);
        repeat (8) tick();
        chk("arst_regrant", lg[2], 1'b0);
        chk_sym("arst_first_byte", 3, 1'b0, 8'hC0);

        // Randomized traffic with stalls and control-valued payload.
        do_reset();
        for (int t = 0; t < 3000; t++) begin
            if (dq0.size() < 30 && $urandom_range(0, 7) == 0) begin
                int len0;
                len0 = $urandom_range(1, 24);
                for (int j = 0; j < len0; j++) push_byte(0, 8'($urandom_range(0, 255)), (j == len0 - 1));
            end
            if (dq1.size() < 30 && $urandom_range(0, 7) == 0) begin
                int len1;
                len1 = $urandom_range(1, 24);
                for (int j = 0; j < len1; j++) push_byte(1, 8'($urandom_range(0, 255)), (j == len1 - 1));
            end
            stall[0] = ($urandom_range(0, 3) == 0);
            stall[1] = ($urandom_range(0, 3) == 0);
            tick();
        end
        stall = 2'b00;
        drained = 1'b0;
        for (int t = 0; t < 800 && !drained; t++) begin
            tick();
            drained = (dq0.size() == 0) && (dq1.size() == 0) && !in_pkt;
        end
        chk("rand_drained", drained, 1'b1);
        chk("rand_exp0_empty", eq0.size(), 0);
        chk("rand_exp1_empty", eq1.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
